// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader:
// FSM state encoding, the RISC-V NOP word and a timeout-counter width helper.
package imem_boot_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CHK   = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_t;

    // Canonical RISC-V NOP (addi x0, x0, 0).
    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    // Width of the inter-byte idle counter: wide enough for the timeout,
    // never narrower than 20 bits.
    function automatic int timeout_width(input int cyc);
        int w;
        w = $clog2(cyc + 1);
        return (w < 20) ? 20 : w;
    endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream handshake between a source (UART RX, debug FIFO) and the
// boot loader. A byte moves when in_valid && in_ready on a rising edge.
interface imem_boot_loader_if;

    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;

    // Byte source side.
    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    // Boot-loader side.
    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );

endinterface

// File: rtl/imem_boot_loader_word_assembler.sv
// Packs four consecutive bytes into a little-endian 32-bit word.
// word_done flags the byte that completes a word (combinational, same cycle
// as that byte is presented) so the controller can step to its write cycle.
module imem_word_assembler (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_done
);

    logic [1:0]  cnt_q;
    logic [1:0]  cnt_d;
    logic [31:0] word_q;
    logic [31:0] word_d;
    logic [3:0]  lane_hit;

    // One lane-select bit per byte position of the word.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_hit[gi] = byte_valid && (cnt_q == 2'(gi));
        end
    endgenerate

    // Next-state: drop the byte into its lane and advance the byte counter.
    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        for (int i = 0; i < 4; i++) begin
            if (lane_hit[i]) begin
                word_d[8*i +: 8] = byte_data;
            end
        end
        if (clear) begin
            cnt_d = 2'd0;
        end else if (byte_valid) begin
            cnt_d = cnt_q + 2'd1;
        end
    end

    // Byte counter and word register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= 2'd0;
            word_q <= 32'd0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
        end
    end

    assign word      = word_q;
    assign word_done = byte_valid && (cnt_q == 2'd3);

endmodule

// File: rtl/imem_boot_loader.sv
// Instruction-memory boot loader. Receives a word count followed by
// little-endian instruction bytes, writes them to instruction memory
// starting at word 0, stalls the core throughout and pulses core_rst after
// a good load. Optional trailing XOR checksum byte when IMEM_CHECKSUM_EN is
// defined.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int DEPTH       = 32,
    parameter int ADDR_W      = 5,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    imem_boot_loader_if.slave    s_in,
    output logic                 imem_we,
    output logic [ADDR_W-1:0]    imem_waddr,
    output logic [31:0]          imem_wdata,
    output logic                 core_hold,
    output logic                 core_rst,
    output logic                 busy,
    output logic                 load_err
);

    localparam int TO_W = timeout_width(TIMEOUT_CYC);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]   last_q, last_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic                hold_q, hold_d;
    logic                err_q, err_d;
`ifdef IMEM_CHECKSUM_EN
    logic [7:0]          xor_q, xor_d;
`endif

    logic                accept;
    logic                counting;
    logic                timed_out;
    logic                asm_clear;
    logic                asm_valid;
    logic                asm_done;
    logic [31:0]         asm_word;

    assign s_in.in_ready = (state_q == ST_LEN) || (state_q == ST_DATA) ||
                           (state_q == ST_CHK);
    assign accept        = s_in.in_valid && s_in.in_ready;
    assign asm_valid     = accept && (state_q == ST_DATA);

    // Idle counter only runs while waiting for stream bytes.
    assign counting  = s_in.in_ready;
    assign timed_out = counting && !accept &&
                       (to_cnt_q == TO_W'(TIMEOUT_CYC - 1));

    imem_word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (asm_clear),
        .byte_valid (asm_valid),
        .byte_data  (s_in.in_data),
        .word       (asm_word),
        .word_done  (asm_done)
    );

    // Next-state and datapath control for the load sequence.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        last_d    = last_q;
        to_cnt_d  = to_cnt_q;
        hold_d    = hold_q;
        err_d     = err_q;
        asm_clear = 1'b0;
`ifdef IMEM_CHECKSUM_EN
        xor_d     = xor_q;
`endif

        if (counting) begin
            to_cnt_d = accept ? '0 : (to_cnt_q + TO_W'(1));
        end

        case (state_q)
            ST_IDLE: begin
                to_cnt_d = '0;
                if (start) begin
                    state_d = ST_LEN;
                    hold_d  = 1'b1;
                    err_d   = 1'b0;
                end
            end
            ST_LEN: begin
                if (accept) begin
                    if (s_in.in_data == 8'd0) begin
                        // Empty image: nothing to load, let the core run again.
                        state_d = ST_IDLE;
                        hold_d  = 1'b0;
                    end else if (int'(s_in.in_data) > DEPTH) begin
                        state_d = ST_ERR;
                    end else begin
                        last_d    = ADDR_W'(s_in.in_data - 8'd1);
                        idx_d     = '0;
                        asm_clear = 1'b1;
`ifdef IMEM_CHECKSUM_EN
                        xor_d     = 8'd0;
`endif
                        state_d   = ST_DATA;
                    end
                end else if (timed_out) begin
                    state_d = ST_ERR;
                end
            end
            ST_DATA: begin
`ifdef IMEM_CHECKSUM_EN
                if (accept) begin
                    xor_d = xor_q ^ s_in.in_data;
                end
`endif
                if (asm_done) begin
                    state_d = ST_WRITE;
                end else if (timed_out) begin
                    state_d = ST_ERR;
                end
            end
            ST_WRITE: begin
                if (idx_q == last_q) begin
`ifdef IMEM_CHECKSUM_EN
                    state_d = ST_CHK;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    idx_d   = idx_q + ADDR_W'(1);
                    state_d = ST_DATA;
                end
            end
`ifdef IMEM_CHECKSUM_EN
            ST_CHK: begin
                if (accept) begin
                    state_d = (s_in.in_data == xor_q) ? ST_DONE : ST_ERR;
                end else if (timed_out) begin
                    state_d = ST_ERR;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
                hold_d  = 1'b0;
            end
            ST_ERR: begin
                // Image is suspect: keep the core stalled after returning idle.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Error flag rises on the same edge the FSM enters ERR.
        if (state_d == ST_ERR) begin
            err_d = 1'b1;
        end
    end

    // State and control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            last_q   <= '0;
            to_cnt_q <= '0;
            hold_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            to_cnt_q <= to_cnt_d;
            hold_q   <= hold_d;
            err_q    <= err_d;
        end
    end

`ifdef IMEM_CHECKSUM_EN
    // Running XOR of all image bytes.
    always_ff @(posedge clk) begin
        if (rst) begin
            xor_q <= 8'd0;
        end else begin
            xor_q <= xor_d;
        end
    end
`endif

    assign imem_we    = (state_q == ST_WRITE);
    assign imem_waddr = idx_q;
    assign imem_wdata = asm_word;
    assign core_hold  = hold_q;
    assign core_rst   = (state_q == ST_DONE);
    assign busy       = (state_q != ST_IDLE);
    assign load_err   = err_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader. Randomized images are checked
// against a write list derived directly from the load protocol.
// Build with IMEM_CHECKSUM_EN defined to exercise the checksum byte.
module tb_imem_boot_loader;
    import imem_boot_loader_pkg::*;

    localparam int DEPTH  = 32;
    localparam int ADDR_W = 5;
    localparam int TO     = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              core_hold;
    logic              core_rst;
    logic              busy;
    logic              load_err;

    imem_boot_loader_if bus ();

    imem_boot_loader #(
        .DEPTH       (DEPTH),
        .ADDR_W      (ADDR_W),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .s_in       (bus),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .core_hold  (core_hold),
        .core_rst   (core_rst),
        .busy       (busy),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int          addr;
        logic [31:0] data;
        bit          lat_ok;
    } wr_t;

    wr_t         wr_q[$];
    int          rst_pulses = 0;
    int          cyc = 0;
    int          last_acc = -10;
    logic [31:0] words[DEPTH];

    always @(posedge clk) cyc <= cyc + 1;

    // Observe writes, core_rst pulses and byte acceptances mid-cycle.
    always @(negedge clk) begin
        if (bus.in_valid && bus.in_ready) last_acc <= cyc;
        if (imem_we) wr_q.push_back('{int'(imem_waddr), imem_wdata, (cyc == last_acc + 1)});
        if (core_rst) rst_pulses <= rst_pulses + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input string tag);
        bit got = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            if (bus.in_ready) got = 1;
        end
        if (got) begin
            @(posedge clk); #1;
        end else begin
            n_checks++;
            $display("FAIL %s accept: byte %02h not accepted in 100 cycles (want accepted)", tag, b);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 0;
        for (int c = 0; c < 60 && !ok; c++) begin
            @(negedge clk);
            if (!busy) ok = 1;
        end
        n_checks++;
        if (!ok) $display("FAIL %s idle: busy=%b after 60 cycles, want 0", tag, busy);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    // Full good load of words[0..n-1]; checks writes, latency and release.
    task automatic run_good_load(input int n, input bit poke_start, input string tag);
        int         wbase = wr_q.size();
        int         rbase = rst_pulses;
        logic [7:0] x = 8'd0;
        logic [7:0] b;
        do_start();
        n_checks++; if (core_hold !== 1'b1) $display("FAIL %s hold_on: got %b want 1", tag, core_hold); else n_pass++;
        n_checks++; if (load_err !== 1'b0) $display("FAIL %s err_clr: got %b want 0", tag, load_err); else n_pass++;
        send_byte(8'(n), tag);
        if (poke_start) do_start();
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) begin
                idle($urandom_range(0, 3));
                b = words[i][8*k +: 8];
                x ^= b;
                send_byte(b, tag);
            end
        end
`ifdef IMEM_CHECKSUM_EN
        idle($urandom_range(0, 3));
        send_byte(x, tag);
`endif
        wait_idle(tag);
        n_checks++;
        if (wr_q.size() - wbase != n) $display("FAIL %s nwrites: got %0d want %0d", tag, wr_q.size() - wbase, n);
        else n_pass++;
        for (int i = 0; i < n && wbase + i < wr_q.size(); i++) begin
            n_checks++;
            if (wr_q[wbase+i].addr != i || wr_q[wbase+i].data !== words[i] || !wr_q[wbase+i].lat_ok)
                $display("FAIL %s write%0d: got addr=%0d data=%08h lat_ok=%0b want addr=%0d data=%08h lat_ok=1",
                         tag, i, wr_q[wbase+i].addr, wr_q[wbase+i].data, wr_q[wbase+i].lat_ok, i, words[i]);
            else n_pass++;
        end
        n_checks++; if (rst_pulses - rbase != 1) $display("FAIL %s core_rst: got %0d pulses want 1", tag, rst_pulses - rbase); else n_pass++;
        n_checks++; if (core_hold !== 1'b0) $display("FAIL %s release: hold=%b want 0", tag, core_hold); else n_pass++;
        n_checks++; if (load_err !== 1'b0) $display("FAIL %s err: got %b want 0", tag, load_err); else n_pass++;
        $display("load %s: N=%0d done", tag, n);
    endtask

    task automatic test_reset();
        idle(1);
        n_checks++;
        if ({bus.in_ready, imem_we, core_hold, core_rst, busy, load_err} !== 6'd0 || imem_waddr !== '0 || imem_wdata !== 32'd0)
            $display("FAIL reset_outputs: got rdy=%b we=%b hold=%b crst=%b busy=%b err=%b waddr=%0d wdata=%08h want all 0",
                     bus.in_ready, imem_we, core_hold, core_rst, busy, load_err, imem_waddr, imem_wdata);
        else n_pass++;
        rst = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus.in_ready !== 1'b0 || busy !== 1'b0) $display("FAIL idle_ready: rdy=%b busy=%b want 0 0", bus.in_ready, busy);
            else n_pass++;
        end
        bus.in_valid = 1'b0;
        idle(1);
        $display("reset: done");
    endtask

    task automatic test_known_vector();
        words[0] = 32'h02A0_0093;
        words[1] = 32'h0100_0113;
        run_good_load(2, 1'b0, "vector");
    endtask

    task automatic test_zero_len();
        int wbase = wr_q.size();
        int rbase = rst_pulses;
        do_start();
        n_checks++; if (core_hold !== 1'b1) $display("FAIL zero hold_on: got %b want 1", core_hold); else n_pass++;
        send_byte(8'd0, "zero");
        n_checks++; if (busy !== 1'b0 || core_hold !== 1'b0) $display("FAIL zero release: busy=%b hold=%b want 0 0", busy, core_hold); else n_pass++;
        idle(3);
        n_checks++;
        if (wr_q.size() != wbase || rst_pulses != rbase || load_err !== 1'b0)
            $display("FAIL zero side: writes=%0d pulses=%0d err=%b want 0 0 0", wr_q.size() - wbase, rst_pulses - rbase, load_err);
        else n_pass++;
        $display("zero_len: done");
    endtask

    task automatic test_too_long();
        int wbase = wr_q.size();
        int rbase = rst_pulses;
        do_start();
        send_byte(8'(DEPTH + 1), "toolong");
        n_checks++; if (load_err !== 1'b1) $display("FAIL toolong err: got %b want 1", load_err); else n_pass++;
        wait_idle("toolong");
        n_checks++;
        if (load_err !== 1'b1 || core_hold !== 1'b1 || wr_q.size() != wbase || rst_pulses != rbase)
            $display("FAIL toolong after: err=%b hold=%b writes=%0d pulses=%0d want 1 1 0 0",
                     load_err, core_hold, wr_q.size() - wbase, rst_pulses - rbase);
        else n_pass++;
        $display("too_long: done");
    endtask

    task automatic test_timeout();
        int wbase = wr_q.size();
        do_start();
        send_byte(8'd1, "timeout");
        send_byte(8'($urandom), "timeout");
        send_byte(8'($urandom), "timeout");
        idle(TO - 1);
        n_checks++; if (load_err !== 1'b0 || busy !== 1'b1) $display("FAIL timeout early: err=%b busy=%b want 0 1", load_err, busy); else n_pass++;
        idle(1);
        n_checks++; if (load_err !== 1'b1) $display("FAIL timeout fire: err=%b want 1", load_err); else n_pass++;
        wait_idle("timeout");
        n_checks++;
        if (core_hold !== 1'b1 || wr_q.size() != wbase)
            $display("FAIL timeout after: hold=%b writes=%0d want 1 0", core_hold, wr_q.size() - wbase);
        else n_pass++;
        $display("timeout: done");
    endtask

    task automatic test_rst_mid_load();
        int rbase = rst_pulses;
        for (int i = 0; i < 2; i++) words[i] = $urandom;
        do_start();
        send_byte(8'd2, "midrst");
        for (int k = 0; k < 4; k++) send_byte(words[0][8*k +: 8], "midrst");
        for (int k = 0; k < 3; k++) send_byte(words[1][8*k +: 8], "midrst");
        rst = 1'b1;
        idle(1);
        n_checks++;
        if ({bus.in_ready, imem_we, core_hold, core_rst, busy, load_err} !== 6'd0 || imem_waddr !== '0 || imem_wdata !== 32'd0)
            $display("FAIL midrst outputs: got rdy=%b we=%b hold=%b crst=%b busy=%b err=%b waddr=%0d wdata=%08h want all 0",
                     bus.in_ready, imem_we, core_hold, core_rst, busy, load_err, imem_waddr, imem_wdata);
        else n_pass++;
        rst = 1'b0;
        idle(2);
        n_checks++; if (rst_pulses != rbase) $display("FAIL midrst core_rst: got %0d pulses want 0", rst_pulses - rbase); else n_pass++;
        for (int i = 0; i < 3; i++) words[i] = $urandom;
        run_good_load(3, 1'b0, "after_rst");
    endtask

    task automatic test_random_loads();
        int n;
        for (int it = 0; it < 6; it++) begin
            n = (it == 0) ? 1 : (it == 1) ? DEPTH : int'($urandom_range(1, DEPTH));
            for (int i = 0; i < n; i++) words[i] = $urandom;
            run_good_load(n, it[0], $sformatf("rand%0d", it));
        end
    endtask

`ifdef IMEM_CHECKSUM_EN
    task automatic test_checksum();
        int rbase;
        logic [31:0] w;
        w = RV_NOP;
        for (int pass = 0; pass < 2; pass++) begin
            rbase = rst_pulses;
            do_start();
            send_byte(8'd1, "chk");
            for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], "chk");
            send_byte((pass == 0) ? 8'h13 : 8'h00, "chk");
            wait_idle("chk");
            n_checks++;
            if (pass == 0 && (rst_pulses - rbase != 1 || load_err !== 1'b0 || core_hold !== 1'b0))
                $display("FAIL chk good: pulses=%0d err=%b hold=%b want 1 0 0", rst_pulses - rbase, load_err, core_hold);
            else if (pass == 1 && (rst_pulses != rbase || load_err !== 1'b1 || core_hold !== 1'b1))
                $display("FAIL chk bad: pulses=%0d err=%b hold=%b want 0 1 1", rst_pulses - rbase, load_err, core_hold);
            else n_pass++;
            $display("checksum pass %0d: done", pass);
        end
    endtask
`endif

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;
        idle(3);
        test_reset();
        test_known_vector();
        test_zero_len();
        test_too_long();
        test_timeout();
        test_rst_mid_load();
        test_random_loads();
`ifdef IMEM_CHECKSUM_EN
        test_checksum();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
